// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Load/store unit for the MEM pipeline stage. It turns a load or store from
// the pipeline into one transaction on a simple request/acknowledge data bus.
// It formats store data and byte enables on the way out and sign- or
// zero-extends load data on the way back. mem_stall holds the pipeline while
// an access is in flight.
//
// Optional build feature (compile-time macro):
//   LSU_MISALIGN_TRAP_EN - misaligned halfword/word accesses are not issued
//                          on the bus. Instead they pulse 'misaligned' for
//                          one cycle and complete with data 0. Without the
//                          macro 'misaligned' is tied low, and misaligned
//                          accesses go out using the normal lane rules.
//
// Parameters:
//   MAX_WAIT          bus acknowledge timeout in BUSY cycles (1..255)
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   flush             kill the access currently in the MEM stage
//   mem_read_ctrl_mem / mem_write_ctrl_mem
//                     load / store request (mutually exclusive)
//   funct3_mem        access size and signedness
//   alu_result_mem    byte address
//   rs2_data_mem      store data
//   dbus_req/we/addr/wdata/be
//                     registered data-bus request (word-aligned address)
//   dbus_ack, dbus_rdata
//                     data-bus acknowledge and read data
//   mem_data_out_mem  formatted load data to MEM/WB (0 for stores/errors)
//   mem_stall         pipeline stall request
//   bus_error         one-cycle pulse on acknowledge timeout
//   misaligned        one-cycle pulse on a trapped misaligned access
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mem_read_ctrl_mem,
  input  logic        mem_write_ctrl_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] rs2_data_mem,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] mem_data_out_mem,
  output logic        mem_stall,
  output logic        bus_error,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The timeout fires in the BUSY cycle whose counter value is MAX_WAIT-1.
  // The counter starts at 0 on entry to BUSY, so this gives exactly
  // MAX_WAIT BUSY cycles.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_n;
  logic [7:0]  wait_cnt, wait_cnt_n;
  logic        kill, kill_n;
  logic        req_n, we_n;
  logic [31:0] addr_n, wdata_n, data_n;
  logic [3:0]  be_n;
  logic        err_n;
  logic [2:0]  ld_f3_q, ld_f3_n;
  logic [1:0]  ld_lane_q, ld_lane_n;

  logic        access;
  logic [1:0]  addr_lo;
  logic        is_byte, is_half, is_word;
  logic [31:0] store_wdata;
  logic [3:0]  lane_be;
  logic        kill_now;

  assign access  = mem_read_ctrl_mem | mem_write_ctrl_mem;
  assign addr_lo = alu_result_mem[1:0];

  // Size decode differs between loads and stores. Loads map 100/101 to
  // LBU/LHU. Stores have no unsigned forms, so any funct3 other than SB/SH
  // is a word store.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (mem_write_ctrl_mem) begin
      is_byte = (funct3_mem == 3'b000);
      is_half = (funct3_mem == 3'b001);
    end else begin
      is_byte = (funct3_mem[1:0] == 2'b00);
      is_half = (funct3_mem[1:0] == 2'b01);
    end
  end

  assign is_word = ~is_byte & ~is_half;

  // Store data is replicated across all lanes, so the byte enables alone
  // select the destination bytes. Loads drive the same lane enables; the
  // bus may ignore them on reads.
  always_comb begin
    store_wdata = rs2_data_mem;
    lane_be     = 4'hF;
    if (is_byte) begin
      store_wdata = {4{rs2_data_mem[7:0]}};
      lane_be     = 4'b0001 << addr_lo;
    end else if (is_half) begin
      store_wdata = {2{rs2_data_mem[15:0]}};
      lane_be     = addr_lo[1] ? 4'b1100 : 4'b0011;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_hit;
  logic mis_n;
  assign misalign_hit = (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
`endif

  // Pick the addressed lane out of the returned word and extend it according
  // to the funct3 latched when the request was issued.
  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b100:  format_load = {24'd0, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b101:  format_load = {16'd0, h};
      default: format_load = rdata;
    endcase
  endfunction

  // A flush in the same cycle as the acknowledge or timeout counts as a kill.
  assign kill_now = kill | flush;

  // The stall stays high for the whole of BUSY. This keeps the pipeline held
  // while a killed access finishes its handshake, even if the pipeline has
  // already dropped its request.
  assign mem_stall = (access && (state != DONE)) || (state == BUSY);

  // Next-state and next-register computation. Every registered output holds
  // its value unless a transition below changes it. The pulse outputs
  // default to 0, so they are high for exactly one cycle.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    kill_n     = kill;
    req_n      = dbus_req;
    we_n       = dbus_we;
    addr_n     = dbus_addr;
    wdata_n    = dbus_wdata;
    be_n       = dbus_be;
    data_n     = mem_data_out_mem;
    err_n      = 1'b0;
    ld_f3_n    = ld_f3_q;
    ld_lane_n  = ld_lane_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_n      = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (access && !flush) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misalign_hit) begin
            state_n = DONE;
            mis_n   = 1'b1;
            data_n  = 32'd0;
          end else begin
`endif
            state_n    = BUSY;
            req_n      = 1'b1;
            we_n       = mem_write_ctrl_mem;
            addr_n     = {alu_result_mem[31:2], 2'b00};
            wdata_n    = mem_write_ctrl_mem ? store_wdata : 32'd0;
            be_n       = lane_be;
            wait_cnt_n = 8'd0;
            kill_n     = 1'b0;
            ld_f3_n    = funct3_mem;
            ld_lane_n  = addr_lo;
`ifdef LSU_MISALIGN_TRAP_EN
          end
`endif
        end
      end

      BUSY: begin
        // Acknowledge is checked first, so it wins over a timeout in the
        // same cycle.
        if (dbus_ack) begin
          req_n      = 1'b0;
          wait_cnt_n = 8'd0;
          kill_n     = 1'b0;
          if (kill_now) begin
            state_n = IDLE;
          end else begin
            state_n = DONE;
            data_n  = dbus_we ? 32'd0 : format_load(ld_f3_q, ld_lane_q, dbus_rdata);
          end
        end else if (wait_cnt == WAIT_LAST) begin
          // A killed access that times out is simply abandoned. The
          // instruction is gone, so there is nobody to report the error to.
          req_n      = 1'b0;
          wait_cnt_n = 8'd0;
          kill_n     = 1'b0;
          if (kill_now) begin
            state_n = IDLE;
          end else begin
            state_n = DONE;
            err_n   = 1'b1;
            data_n  = 32'd0;
          end
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
          kill_n     = kill_now;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any bus transaction in
  // progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wait_cnt         <= 8'd0;
      kill             <= 1'b0;
      dbus_req         <= 1'b0;
      dbus_we          <= 1'b0;
      dbus_addr        <= 32'd0;
      dbus_wdata       <= 32'd0;
      dbus_be          <= 4'd0;
      mem_data_out_mem <= 32'd0;
      bus_error        <= 1'b0;
      ld_f3_q          <= 3'd0;
      ld_lane_q        <= 2'd0;
    end else begin
      state            <= state_n;
      wait_cnt         <= wait_cnt_n;
      kill             <= kill_n;
      dbus_req         <= req_n;
      dbus_we          <= we_n;
      dbus_addr        <= addr_n;
      dbus_wdata       <= wdata_n;
      dbus_be          <= be_n;
      mem_data_out_mem <= data_n;
      bus_error        <= err_n;
      ld_f3_q          <= ld_f3_n;
      ld_lane_q        <= ld_lane_n;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= mis_n;
    end
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 15, bus-ack timeout in cycles (range 1..255).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: flush  in  1  kill in-flight MEM-stage access.
REQ-005 SHALL have ports: mem_read_ctrl_mem, mem_write_ctrl_mem  in  1  load/store request, mutually exclusive.
REQ-006 SHALL have ports: funct3_mem  in  3  size/sign; alu_result_mem  in  32  byte address; rs2_data_mem  in  32  store data.
REQ-007 SHALL have ports: dbus_req, dbus_we  out  1; dbus_addr  out  32  word-aligned; dbus_wdata  out  32; dbus_be  out  4.
REQ-008 SHALL have ports: dbus_ack  in  1; dbus_rdata  in  32.
REQ-009 SHALL have ports: mem_data_out_mem  out  32  formatted load data to MEM/WB; mem_stall  out  1; bus_error  out  1; misaligned  out  1.

Function
REQ-010 SHALL implement FSM IDLE, BUSY, DONE; IDLE with read or write and no flush -> BUSY, registering dbus_req=1, dbus_we, dbus_addr={addr[31:2],2'b00}, dbus_wdata, dbus_be.
REQ-011 SHALL hold every dbus_* output stable in BUSY until the cycle dbus_ack=1, then deassert dbus_req at the next edge.
REQ-012 SHALL on ack in BUSY register formatted load data (stores: 0) into mem_data_out_mem and go DONE; DONE -> IDLE after exactly one cycle.
REQ-013 SHALL drive mem_stall = (read|write) && state!=DONE, combinationally; ack in first BUSY cycle gives 2 stall cycles, data valid and stall low the cycle after ack.
REQ-014 SHALL count BUSY cycles; on reaching MAX_WAIT without ack: drop dbus_req, pulse bus_error one cycle, load mem_data_out_mem=0, go DONE.
REQ-015 SHALL format stores: SB wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, be=addr[1]?4'b1100:4'b0011; SW be=4'hF.
REQ-016 SHALL format loads from lane addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; other funct3 treated as LW/SW.
REQ-017 SHALL on flush in IDLE/DONE go IDLE next edge; on flush in BUSY set kill flag, finish bus handshake, then go IDLE (not DONE), keep mem_stall high until then, clear kill.
REQ-018 SHALL give ack and timeout in the same cycle priority to ack.
REQ-019 SHALL ignore dbus_ack outside BUSY.

Reset
REQ-020 SHALL on rst_n=0 asynchronously force state IDLE, counter 0, kill 0, all outputs 0.
REQ-021 SHALL abandon any bus transaction on reset mid-BUSY; first request after release starts a fresh IDLE->BUSY.

Configuration
REQ-022 SHALL with LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 issues no bus cycle, pulses misaligned one cycle, IDLE->DONE with data 0 (1 stall cycle).
REQ-023 SHALL without LSU_MISALIGN_TRAP_EN: misaligned tied 0; misaligned accesses issue normally using lane rules of REQ-015/016.

Verification
REQ-024 SHALL cover: LW addr 0x100, ack 1st BUSY cycle, rdata 0xDEADBEEF -> dbus_addr 0x100, 2 stall cycles, mem_data_out_mem 0xDEADBEEF.
REQ-025 SHALL cover: LB addr 0x103, rdata 0x80FFFFFF -> 0xFFFFFF80; LBU same -> 0x00000080.
REQ-026 SHALL cover: SH addr 0x202, rs2 0x1234ABCD -> dbus_we=1, dbus_be 4'b1100, dbus_wdata 0xABCDABCD.
REQ-027 SHALL cover: LW, no ack, MAX_WAIT=4 -> bus_error pulse after 4 BUSY cycles, data 0, stall released next cycle.
REQ-028 SHALL cover: flush in 2nd BUSY cycle, ack on 3rd -> no DONE, state IDLE, mem_data_out_mem unchanged.
REQ-029 SHALL cover: with macro, LW addr 0x101 -> dbus_req stays 0, misaligned pulse, 1 stall cycle.
